regfile_write_arbiter: RTL and testbench

//   Owns the chip's REGCOUNT x 8-bit configuration register file and arbitrates its single

---
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   REGCOUNT x 8-bit configuration register file with one write port. The I2C
//   slave and the parallel-capture path share that port. A lone request is
//   granted in the same cycle. When both sides request, the side that lost the
//   last contested cycle wins (round robin), so each side waits at most one cycle.
//   Writes to an out-of-range address are granted but dropped, and addr_err
//   pulses for one cycle after the drop.
//   Optional build macro: REGFILE_WPROT_EN. When it is defined, bit 0 of
//   register 0 is a lock. While the lock is set, parallel-side writes are
//   granted, dropped and flagged with addr_err.
module regfile_write_arbiter #(
  parameter int REGCOUNT = 20,
  parameter int ADDR_W   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i2c_req,
  input  logic [ADDR_W-1:0]     i2c_addr,
  input  logic [7:0]            i2c_wdata,
  output logic                  i2c_gnt,
  input  logic                  par_req,
  input  logic [ADDR_W-1:0]     par_addr,
  input  logic [7:0]            par_wdata,
  output logic                  par_gnt,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic                  addr_err,
  output logic [7:0]            conflict_count
);

  // Records which side won the most recent contested cycle.
  typedef enum logic {
    RR_I2C = 1'b0,
    RR_PAR = 1'b1
  } rr_e;

  rr_e               rr_last;
  rr_e               rr_next;
  logic              contested;
  logic [7:0]        regs [REGCOUNT];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              in_range;
  logic              locked;
  logic              drop;

  // Arbitration: grants are combinational and both are held low while reset is high.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned (which would infer a latch).
    i2c_gnt   = 1'b0;
    par_gnt   = 1'b0;
    rr_next   = rr_last;
    contested = i2c_req & par_req;
    if (!reset) begin
      if (contested) begin
        if (rr_last == RR_PAR) begin
          i2c_gnt = 1'b1;
          rr_next = RR_I2C;
        end else begin
          par_gnt = 1'b1;
          rr_next = RR_PAR;
        end
      end else begin
        i2c_gnt = i2c_req;
        par_gnt = par_req;
      end
    end
  end

  // Write port mux and drop decision for the granted request.
  always_comb begin
    wr_en    = i2c_gnt | par_gnt;
    wr_addr  = par_gnt ? par_addr : i2c_addr;
    wr_data  = par_gnt ? par_wdata : i2c_wdata;
    // The extra bit keeps the compare correct when REGCOUNT == 2**ADDR_W.
    in_range = {1'b0, wr_addr} < (ADDR_W+1)'(REGCOUNT);
`ifdef REGFILE_WPROT_EN
    // The lock is read from the current register value, that is, the value at the start of the grant cycle.
    locked   = par_gnt & regs[0][0];
`else
    locked   = 1'b0;
`endif
    drop     = ~in_range | locked;
  end

  // Register file, round-robin pointer, error pulse and conflict counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this register file is built from flops, not a RAM macro, so clearing every entry on reset is cheap and required.
      for (int k = 0; k < REGCOUNT; k++) regs[k] <= 8'h00;
      rr_last        <= RR_PAR;
      addr_err       <= 1'b0;
      conflict_count <= 8'h00;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments, so every flop samples values from before the edge.
      rr_last  <= rr_next;
      addr_err <= wr_en & drop;
      if (contested && conflict_count != 8'hFF)
        conflict_count <= conflict_count + 8'd1;
      for (int k = 0; k < REGCOUNT; k++)
        if (wr_en && !drop && wr_addr == ADDR_W'(k))
          regs[k] <= wr_data;
    end
  end

  // Flatten the register file: register k sits at bits [8k+7:8k].
  always_comb begin
    registers_packed = '0;
    for (int k = 0; k < REGCOUNT; k++)
      registers_packed[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench. It runs a table of single-cycle vectors with hand-computed
//   expected values, followed by hand-written sequences for reset mid-operation,
//   saturation of the conflict counter and the optional write-protect lock.
//   Inputs change on the falling edge. Grants are checked just after the inputs
//   change, and registered outputs are checked 1 ns after the rising edge.
module tb_regfile_write_arbiter;

  localparam int REGCOUNT = 20;
  localparam int ADDR_W   = 5;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  i2c_req = 1'b0;
  logic [ADDR_W-1:0]     i2c_addr = '0;
  logic [7:0]            i2c_wdata = '0;
  logic                  i2c_gnt;
  logic                  par_req = 1'b0;
  logic [ADDR_W-1:0]     par_addr = '0;
  logic [7:0]            par_wdata = '0;
  logic                  par_gnt;
  logic [8*REGCOUNT-1:0] registers_packed;
  logic                  addr_err;
  logic [7:0]            conflict_count;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter #(.REGCOUNT(REGCOUNT), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .i2c_req          (i2c_req),
    .i2c_addr         (i2c_addr),
    .i2c_wdata        (i2c_wdata),
    .i2c_gnt          (i2c_gnt),
    .par_req          (par_req),
    .par_addr         (par_addr),
    .par_wdata        (par_wdata),
    .par_gnt          (par_gnt),
    .registers_packed (registers_packed),
    .addr_err         (addr_err),
    .conflict_count   (conflict_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ir;
    logic [4:0] ia;
    logic [7:0] id;
    logic       pr;
    logic [4:0] pa;
    logic [7:0] pd;
    logic       e_ig;
    logic       e_pg;
    int         ridx;
    logic [7:0] e_reg;
    logic       e_err;
    logic [7:0] e_cc;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int idx);
    return registers_packed[8*idx +: 8];
  endfunction

  task automatic apply(input logic ir, input logic [4:0] ia, input logic [7:0] id,
                       input logic pr, input logic [4:0] pa, input logic [7:0] pd);
    @(negedge clock);
    i2c_req = ir; i2c_addr = ia; i2c_wdata = id;
    par_req = pr; par_addr = pa; par_wdata = pd;
  endtask

  task automatic do_reset();
    apply(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Register values are read back after the rising edge that ends each vector.
    vec[0]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 0,  8'h00, 1'b0, 8'd0};
    vec[1]  = '{1'b1, 5'd3,  8'hA5, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 3,  8'hA5, 1'b0, 8'd0};
    vec[2]  = '{1'b1, 5'd4,  8'h11, 1'b1, 5'd4,  8'h22, 1'b1, 1'b0, 4,  8'h11, 1'b0, 8'd1};
    vec[3]  = '{1'b0, 5'd4,  8'h11, 1'b1, 5'd4,  8'h22, 1'b0, 1'b1, 4,  8'h22, 1'b0, 8'd1};
    vec[4]  = '{1'b1, 5'd5,  8'h55, 1'b1, 5'd6,  8'h66, 1'b0, 1'b1, 6,  8'h66, 1'b0, 8'd2};
    vec[5]  = '{1'b1, 5'd5,  8'h55, 1'b0, 5'd6,  8'h66, 1'b1, 1'b0, 5,  8'h55, 1'b0, 8'd2};
    vec[6]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd25, 8'h77, 1'b0, 1'b1, 4,  8'h22, 1'b1, 8'd2};
    vec[7]  = '{1'b0, 5'd0,  8'h00, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 4,  8'h22, 1'b0, 8'd2};
    vec[8]  = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd19, 8'h9C, 1'b0, 1'b1, 19, 8'h9C, 1'b0, 8'd2};
    vec[9]  = '{1'b1, 5'd31, 8'hEE, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 3,  8'hA5, 1'b1, 8'd2};
    vec[10] = '{1'b1, 5'd7,  8'h01, 1'b1, 5'd31, 8'h02, 1'b1, 1'b0, 7,  8'h01, 1'b0, 8'd3};
    vec[11] = '{1'b0, 5'd7,  8'h01, 1'b1, 5'd31, 8'h02, 1'b0, 1'b1, 7,  8'h01, 1'b1, 8'd3};

    // Reset state, checked with the bus idle.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset registers_packed", registers_packed, '0);
    check("reset i2c_gnt", i2c_gnt, 1'b0);
    check("reset par_gnt", par_gnt, 1'b0);
    check("reset addr_err", addr_err, 1'b0);
    check("reset conflict_count", conflict_count, 8'd0);

    // Table of single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      apply(vec[i].ir, vec[i].ia, vec[i].id, vec[i].pr, vec[i].pa, vec[i].pd);
      #1;
      check($sformatf("v%0d i2c_gnt", i), i2c_gnt, vec[i].e_ig);
      check($sformatf("v%0d par_gnt", i), par_gnt, vec[i].e_pg);
      @(posedge clock);
      #1;
      check($sformatf("v%0d reg%0d", i, vec[i].ridx), reg_at(vec[i].ridx), vec[i].e_reg);
      check($sformatf("v%0d addr_err", i), addr_err, vec[i].e_err);
      check($sformatf("v%0d conflict_count", i), conflict_count, vec[i].e_cc);
    end

    // Reset asserted while both sides request: no grants and no commit. After
    // release the tie is re-arbitrated, and I2C wins first.
    apply(1'b1, 5'd8, 8'hAB, 1'b1, 5'd9, 8'hCD);
    reset = 1'b1;
    #1;
    check("mid-reset i2c_gnt", i2c_gnt, 1'b0);
    check("mid-reset par_gnt", par_gnt, 1'b0);
    @(posedge clock);
    #1;
    check("mid-reset registers_packed", registers_packed, '0);
    check("mid-reset conflict_count", conflict_count, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post-reset i2c_gnt", i2c_gnt, 1'b1);
    check("post-reset par_gnt", par_gnt, 1'b0);
    @(posedge clock);
    #1;
    check("post-reset reg8", reg_at(8), 8'hAB);
    check("post-reset conflict_count", conflict_count, 8'd1);
    apply(1'b0, 5'd8, 8'hAB, 1'b1, 5'd9, 8'hCD);
    #1;
    check("loser par_gnt", par_gnt, 1'b1);
    @(posedge clock);
    #1;
    check("loser reg9", reg_at(9), 8'hCD);

    // 300 contested cycles: grants alternate starting with I2C, and the counter saturates.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      logic [7:0] exp_cc;
      d = 8'(i);
      exp_cc = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      apply(1'b1, 5'd10, d, 1'b1, 5'd11, ~d);
      #1;
      check($sformatf("sat%0d i2c_gnt", i), i2c_gnt, (i % 2 == 0));
      check($sformatf("sat%0d par_gnt", i), par_gnt, (i % 2 == 1));
      @(posedge clock);
      #1;
      check($sformatf("sat%0d conflict_count", i), conflict_count, exp_cc);
    end
    check("sat reg10", reg_at(10), 8'h2A);
    check("sat reg11", reg_at(11), 8'hD4);

    // Lock bit in register 0.
    do_reset();
    apply(1'b1, 5'd0, 8'h01, 1'b0, 5'd0, 8'h00);
    @(posedge clock);
    #1;
    check("lock set reg0", reg_at(0), 8'h01);
    apply(1'b0, 5'd0, 8'h00, 1'b1, 5'd2, 8'h33);
    #1;
    check("locked par_gnt", par_gnt, 1'b1);
    @(posedge clock);
    #1;
`ifdef REGFILE_WPROT_EN
    check("locked reg2", reg_at(2), 8'h00);
    check("locked addr_err", addr_err, 1'b1);
    apply(1'b1, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
    @(posedge clock);
    #1;
    check("unlock addr_err", addr_err, 1'b0);
    check("unlock reg0", reg_at(0), 8'h00);
    apply(1'b0, 5'd0, 8'h00, 1'b1, 5'd2, 8'h33);
    @(posedge clock);
    #1;
`endif
    check("par write reg2", reg_at(2), 8'h33);
    check("par write addr_err", addr_err, 1'b0);
    apply(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
